iter_mdu: RTL and testbench

Parametrised iterative RV32M/RV64M multiply/divide unit that replaces the fixed 32-bit `mul_div` instance inside the execute stage. It adds configurable data width and bits-per-cycle, a start/done handshake driving the stage stall, pipeline flush, single-cycle special-case division, and a one-entry quotient/remainder cache. The cache lets a DIV/REM pair on the same operands complete in one cycle.

---
 rtl/iter_mdu.sv | 184 ++++++++++++++++++
 tb/tb_iter_mdu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/iter_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, single-cycle special cases and a one-entry div/rem cache.
module iter_mdu #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            stallreq_o,
  output logic [1:0]      dbg_state_o
);
  // Handshake: start_i is held high until the one-cycle done_o pulse; it is only
  // sampled in IDLE, and stallreq_o stays high while a request waits on done_o.
  localparam int N  = XLEN / STEPS;
  localparam int CW = $clog2(N);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_n;

  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            neg_q, neg_r_q, sgn_q;
  logic [XLEN-1:0] a_raw_q, b_raw_q;

  logic            c_valid, c_signed;
  logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;

  logic            is_div, div_signed, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, cache_hit, fast, accept;
  logic [XLEN-1:0] fast_res;

  assign is_div     = op_i[2];
  assign div_signed = ~op_i[0];
  assign a_signed   = (op_i == 3'd1) | (op_i == 3'd2) | (is_div & div_signed);
  assign b_signed   = (op_i == 3'd1) | (is_div & div_signed);
  assign a_neg      = a_signed & rs1_i[XLEN-1];
  assign b_neg      = b_signed & rs2_i[XLEN-1];
  assign a_mag      = a_neg ? -rs1_i : rs1_i;
  assign b_mag      = b_neg ? -rs2_i : rs2_i;

  assign div_zero  = is_div & (rs2_i == '0);
  assign div_ovf   = is_div & div_signed & (rs1_i == INT_MIN) & (&rs2_i);
  assign cache_hit = is_div & c_valid & (rs1_i == c_a) & (rs2_i == c_b) & (div_signed == c_signed);
  assign fast      = div_zero | div_ovf | cache_hit;
  assign accept    = (state == IDLE) & start_i & ~flush_i;

  always_comb begin
    fast_res = '0;
    if (div_zero)     fast_res = op_i[1] ? rs1_i : '1;
    else if (div_ovf) fast_res = op_i[1] ? '0 : rs1_i;
    else              fast_res = op_i[1] ? c_rem : c_quo;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = fast ? DONE : CALC;
      CALC:    if (cnt == CW'(N - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  // One clock of the iteration: STEPS radix-2 steps of either datapath.
  logic [XLEN-1:0] step_hi, step_lo;
  always_comb begin : step_blk
    logic [XLEN:0] sum, t, d;
    step_hi = hi_q;
    step_lo = lo_q;
    sum     = '0;
    t       = '0;
    d       = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (op_q[2]) begin
        t = {step_hi, step_lo[XLEN-1]};
        d = t - {1'b0, b_q};
        if (!d[XLEN]) begin
          step_hi = d[XLEN-1:0];
          step_lo = {step_lo[XLEN-2:0], 1'b1};
        end else begin
          step_hi = t[XLEN-1:0];
          step_lo = {step_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, b_q} : '0);
        step_lo = {sum[0], step_lo[XLEN-1:1]};
        step_hi = sum[XLEN:1];
      end
    end
  end

  // Sign correction applied in FIX.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fix_res;
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    quo     = neg_q ? -lo_q : lo_q;
    rem     = neg_r_q ? -hi_q : hi_q;
    fix_res = '0;
    if (op_q[2])               fix_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                       fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      sgn_q     <= 1'b0;
      a_raw_q   <= '0;
      b_raw_q   <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
      c_valid   <= 1'b0;
      c_signed  <= 1'b0;
      c_a       <= '0;
      c_b       <= '0;
      c_quo     <= '0;
      c_rem     <= '0;
    end else if (accept) begin
      op_q      <= op_i;
      rd_addr_o <= rd_addr_i;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= is_div ? a_mag : b_mag;
      b_q       <= is_div ? b_mag : a_mag;
      neg_q     <= a_neg ^ b_neg;
      neg_r_q   <= a_neg;
      sgn_q     <= div_signed;
      a_raw_q   <= rs1_i;
      b_raw_q   <= rs2_i;
      if (fast) result_o <= fast_res;
    end else if (!flush_i) begin
      if (state == CALC) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
        cnt  <= (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
      end else if (state == FIX) begin
        result_o <= fix_res;
        // Both quotient and remainder are available here, so either op fills the cache.
        if (op_q[2]) begin
          c_valid  <= 1'b1;
          c_signed <= sgn_q;
          c_a      <= a_raw_q;
          c_b      <= b_raw_q;
          c_quo    <= quo;
          c_rem    <= rem;
        end
      end
    end
  end

  assign busy_o      = (state == CALC) | (state == FIX);
  assign done_o      = (state == DONE);
  assign stallreq_o  = start_i & ~done_o;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_iter_mdu.sv
// Directed bench for iter_mdu: a 32-bit/1-step instance and a 64-bit/4-step instance.
module tb_iter_mdu;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, done, stall;
  logic [31:0] res;
  logic [4:0]  rd_o;
  logic [1:0]  dbg;

  logic        start64;
  logic [2:0]  op64;
  logic [63:0] a64, b64;
  logic [4:0]  rd64;
  logic        busy64, done64, stall64;
  logic [63:0] res64;
  logic [4:0]  rd_o64;
  logic [1:0]  dbg64;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  iter_mdu #(.XLEN(32), .STEPS(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_addr_i(rd), .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(res),
    .rd_addr_o(rd_o), .stallreq_o(stall), .dbg_state_o(dbg)
  );

  iter_mdu #(.XLEN(64), .STEPS(4)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .op_i(op64), .rs1_i(a64), .rs2_i(b64),
    .rd_addr_i(rd64), .flush_i(flush), .busy_o(busy64), .done_o(done64), .result_o(res64),
    .rd_addr_o(rd_o64), .stallreq_o(stall64), .dbg_state_o(dbg64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit, hold start until done, check result and timing.
  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp_res,
                       input int exp_lat);
    int lat, busy_n;
    logic seen;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
    #1;
    check({tag, "_stall_accept"}, stall, 1'b1);
    exp_q.push_back(exp_res);
    last_res = exp_res;
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, (exp_lat == 1) ? 0 : exp_lat - 1);
    check({tag, "_result"}, res, exp_q.pop_front());
    check({tag, "_rd_addr"}, rd_o, r);
    check({tag, "_stall_done"}, stall, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat, busy_n, nd;
    logic seen;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; rd64 = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", res, 32'h0);
    check("rst_rd", rd_o, 5'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_done64", done64, 1'b0);
    check("rst_result64", res64, 64'h0);
    rst = 1'b0;

    run32("mul",    3'd0, 32'hFFFF_FFFF, 32'd2,        5'd1, 32'hFFFF_FFFE, 34);
    run32("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 34);
    run32("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 34);
    run32("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h7FFF_FFFF, 34);
    run32("mulh_neg", 3'd1, 32'hFFFF_FFFD, 32'd5,       5'd5, 32'hFFFF_FFFF, 34);
    run32("mul_neg",  3'd0, 32'hFFFF_FFFD, 32'd5,       5'd6, 32'hFFFF_FFF1, 34);

    run32("div",      3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFD, 34);
    run32("rem_hit",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFF, 1);
    run32("remu_miss",3'd7, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'h0000_0001, 34);
    run32("divu_hit", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'h7FFF_FFFC, 1);

    run32("divu_zero", 3'd5, 32'h0000_3039, 32'd0,        5'd11, 32'hFFFF_FFFF, 1);
    run32("remu_zero", 3'd7, 32'h0000_0005, 32'd0,        5'd12, 32'h0000_0005, 1);
    run32("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1);
    run32("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run32("cache_kept",3'd5, 32'hFFFF_FFF9, 32'd2,        5'd15, 32'h7FFF_FFFC, 1);

    run32("div_negdiv", 3'd4, 32'd100,       32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2, 34);
    run32("rem_negdiv", 3'd6, 32'd100,       32'hFFFF_FFF9, 5'd17, 32'h0000_0002, 1);
    run32("divu_big",   3'd5, 32'hFFFF_FFFF, 32'h10,        5'd18, 32'h0FFF_FFFF, 34);
    run32("remu_big",   3'd7, 32'hFFFF_FFFF, 32'h10,        5'd19, 32'h0000_000F, 1);

    // Flush while the counter sits at 10.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd7; rd = 5'd20;
    repeat (11) @(posedge clk);
    #1;
    check("flush_busy_before", busy, 1'b1);
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_state", dbg, 2'd0);
    check("flush_result_kept", res, last_res);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("flush_no_done", nd, 0);

    // Reset landing in the FIX cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd22;
    repeat (33) @(posedge clk);
    #1;
    check("fix_state", dbg, 2'd2);
    check("fix_busy", busy, 1'b1);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rstfix_done", done, 1'b0);
    check("rstfix_busy", busy, 1'b0);
    check("rstfix_result", res, 32'h0);
    check("rstfix_rd", rd_o, 5'd0);
    check("rstfix_state", dbg, 2'd0);
    rst = 1'b0;
    // Cache was cleared by reset, so this REM takes the full iteration.
    run32("rem_after_rst", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd23, 32'hFFFF_FFFF, 34);

    // 64-bit, 4 bits per cycle.
    @(negedge clk);
    start64 = 1'b1; op64 = 3'd5; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd3; rd64 = 5'd21;
    #1;
    check("divu64_stall_accept", stall64, 1'b1);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done64) seen = 1'b1;
      else if (busy64) busy_n++;
    end
    check("divu64_done_seen", seen, 1'b1);
    check("divu64_latency", lat, 18);
    check("divu64_busy_cycles", busy_n, 17);
    check("divu64_result", res64, 64'h5555_5555_5555_5555);
    check("divu64_rd_addr", rd_o64, 5'd21);
    start64 = 1'b0;
    @(posedge clk); #1;
    check("divu64_done_pulse", done64, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
